// File: rtl/vx_barrier_table.sv
// Multi-entry warp barrier table: tracks outstanding barriers and emits completed
// or aborted barriers through a registered valid/ready release port.
module vx_barrier_table #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic [NB_BITS-1:0]   req_id,
    input  logic [NW_BITS-1:0]   req_size_m1,
    output logic                 req_ready,
    input  logic                 abort_valid,
    input  logic [NB_BITS-1:0]   abort_id,
    output logic                 abort_ready,
    output logic                 rel_valid,
    output logic [NB_BITS-1:0]   rel_id,
    output logic [NUM_WARPS-1:0] rel_wmask,
    output logic                 rel_abort,
    input  logic                 rel_ready,
    output logic [NUM_WARPS-1:0] stalled_mask,
    output logic                 err_valid,
    output logic [NB_BITS-1:0]   err_id
);

    logic [NUM_BARRIERS-1:0] active_q, active_d;
    logic [NUM_WARPS-1:0]    mask_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    mask_d  [NUM_BARRIERS];
    logic [NW_BITS-1:0]      count_q [NUM_BARRIERS];
    logic [NW_BITS-1:0]      count_d [NUM_BARRIERS];
    logic [NW_BITS-1:0]      size_q  [NUM_BARRIERS];
    logic [NW_BITS-1:0]      size_d  [NUM_BARRIERS];

    logic                 slot_free, req_fire, abort_fire;
    logic [NUM_WARPS-1:0] wbit, stalled_d;
    logic                 load_rel, load_abort, err_d;
    logic [NB_BITS-1:0]   load_id, err_id_d;
    logic [NUM_WARPS-1:0] load_wmask;

    // A new release may only be loaded when the output slot is empty or draining.
    assign slot_free   = !rel_valid || rel_ready;
    assign abort_ready = slot_free;
    assign req_ready   = slot_free && !abort_valid;
    assign req_fire    = req_valid && req_ready;
    assign abort_fire  = abort_valid && abort_ready;
    assign wbit        = NUM_WARPS'(1) << req_wid;

    always_comb begin
        active_d   = active_q;
        mask_d     = mask_q;
        count_d    = count_q;
        size_d     = size_q;
        load_rel   = 1'b0;
        load_abort = 1'b0;
        load_id    = '0;
        load_wmask = '0;
        err_d      = 1'b0;
        err_id_d   = '0;
        stalled_d  = '0;

        if (abort_fire) begin
            if (active_q[abort_id]) begin
                active_d[abort_id] = 1'b0;
                mask_d[abort_id]   = '0;
                count_d[abort_id]  = '0;
                size_d[abort_id]   = '0;
                load_rel   = 1'b1;
                load_abort = 1'b1;
                load_id    = abort_id;
                load_wmask = mask_q[abort_id];
            end else begin
                err_d    = 1'b1;
                err_id_d = abort_id;
            end
        end else if (req_fire) begin
            // A warp may wait on only one barrier, and sizes must agree with the first arrival.
            if ((stalled_mask & wbit) != '0 ||
                (active_q[req_id] && req_size_m1 != size_q[req_id])) begin
                err_d    = 1'b1;
                err_id_d = req_id;
            end else if (!active_q[req_id]) begin
                if (req_size_m1 == '0) begin
                    load_rel   = 1'b1;
                    load_id    = req_id;
                    load_wmask = wbit;
                end else begin
                    active_d[req_id] = 1'b1;
                    mask_d[req_id]   = wbit;
                    count_d[req_id]  = NW_BITS'(1);
                    size_d[req_id]   = req_size_m1;
                end
            end else if (count_q[req_id] == req_size_m1) begin
                active_d[req_id] = 1'b0;
                mask_d[req_id]   = '0;
                count_d[req_id]  = '0;
                size_d[req_id]   = '0;
                load_rel   = 1'b1;
                load_id    = req_id;
                load_wmask = mask_q[req_id] | wbit;
            end else begin
                mask_d[req_id]  = mask_q[req_id] | wbit;
                count_d[req_id] = count_q[req_id] + NW_BITS'(1);
            end
        end

        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (active_d[b]) stalled_d = stalled_d | mask_d[b];
        end
    end

    // Table state, release slot and error pulse all update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q     <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_q[b]  <= '0;
                count_q[b] <= '0;
                size_q[b]  <= '0;
            end
            rel_valid    <= 1'b0;
            rel_id       <= '0;
            rel_wmask    <= '0;
            rel_abort    <= 1'b0;
            stalled_mask <= '0;
            err_valid    <= 1'b0;
            err_id       <= '0;
        end else begin
            active_q     <= active_d;
            mask_q       <= mask_d;
            count_q      <= count_d;
            size_q       <= size_d;
            stalled_mask <= stalled_d;
            err_valid    <= err_d;
            err_id       <= err_id_d;
            if (load_rel) begin
                rel_valid <= 1'b1;
                rel_id    <= load_id;
                rel_wmask <= load_wmask;
                rel_abort <= load_abort;
            end else if (rel_ready) begin
                rel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vx_barrier_table.sv
// Self-checking bench for vx_barrier_table: directed scenarios with literal
// expectations plus randomized traffic compared against a warp-centric model.
module tb_vx_barrier_table;

    localparam int NW = 4;
    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [1:0] req_wid;
    logic [2:0] req_id;
    logic [1:0] req_size_m1;
    logic       req_ready;
    logic       abort_valid;
    logic [2:0] abort_id;
    logic       abort_ready;
    logic       rel_valid;
    logic [2:0] rel_id;
    logic [3:0] rel_wmask;
    logic       rel_abort;
    logic       rel_ready;
    logic [3:0] stalled_mask;
    logic       err_valid;
    logic [2:0] err_id;

    int checks = 0;
    int fails  = 0;

    vx_barrier_table #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_wid(req_wid), .req_id(req_id),
        .req_size_m1(req_size_m1), .req_ready(req_ready),
        .abort_valid(abort_valid), .abort_id(abort_id), .abort_ready(abort_ready),
        .rel_valid(rel_valid), .rel_id(rel_id), .rel_wmask(rel_wmask),
        .rel_abort(rel_abort), .rel_ready(rel_ready),
        .stalled_mask(stalled_mask), .err_valid(err_valid), .err_id(err_id)
    );

    always #5 clk = ~clk;

    // Model: each warp records which barrier it waits on (-1 = free); a barrier's
    // mask and count are derived from that, so no per-entry mask/count is stored.
    int         wait_on [NW];
    bit         m_active [NB];
    int         m_size [NB];
    bit         m_rel_valid;
    int         m_rel_id;
    logic [3:0] m_rel_wmask;
    bit         m_rel_abort;
    bit         m_err_valid;
    int         m_err_id;

    function automatic logic [3:0] members(int b);
        logic [3:0] m = '0;
        for (int w = 0; w < NW; w++) if (wait_on[w] == b) m[w] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) wait_on[w] = -1;
        for (int b = 0; b < NB; b++) begin
            m_active[b] = 1'b0;
            m_size[b]   = 0;
        end
        m_rel_valid = 0; m_rel_id = 0; m_rel_wmask = '0; m_rel_abort = 0;
        m_err_valid = 0; m_err_id = 0;
    endtask

    task automatic model_release(int b, logic [3:0] wm, bit ab);
        m_rel_valid = 1; m_rel_id = b; m_rel_wmask = wm; m_rel_abort = ab;
        for (int w = 0; w < NW; w++) if (wait_on[w] == b) wait_on[w] = -1;
        m_active[b] = 0;
        m_size[b]   = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                bit free_slot;
                int w, b;
                free_slot   = !m_rel_valid || rel_ready;
                m_err_valid = 0;
                m_err_id    = 0;
                if (m_rel_valid && rel_ready) m_rel_valid = 0;
                if (abort_valid && free_slot) begin
                    b = int'(abort_id);
                    if (m_active[b]) model_release(b, members(b), 1);
                    else begin m_err_valid = 1; m_err_id = b; end
                end else if (req_valid && free_slot) begin
                    w = int'(req_wid);
                    b = int'(req_id);
                    if (wait_on[w] != -1 || (m_active[b] && m_size[b] != int'(req_size_m1))) begin
                        m_err_valid = 1; m_err_id = b;
                    end else if ($countones(members(b)) + 1 == int'(req_size_m1) + 1) begin
                        model_release(b, members(b) | (4'b1 << w), 0);
                    end else begin
                        wait_on[w]  = b;
                        m_active[b] = 1;
                        m_size[b]   = int'(req_size_m1);
                    end
                end
            end
        end
    end

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check_output("cmp_req_ready", 32'(req_ready),
                         32'((!m_rel_valid || rel_ready) && !abort_valid));
            check_output("cmp_abort_ready", 32'(abort_ready), 32'(!m_rel_valid || rel_ready));
            check_output("cmp_rel_valid", 32'(rel_valid), 32'(m_rel_valid));
            if (m_rel_valid) begin
                check_output("cmp_rel_id", 32'(rel_id), 32'(m_rel_id));
                check_output("cmp_rel_wmask", 32'(rel_wmask), 32'(m_rel_wmask));
                check_output("cmp_rel_abort", 32'(rel_abort), 32'(m_rel_abort));
            end
            check_output("cmp_stalled", 32'(stalled_mask), 32'(members(-2) | stall_all()));
            check_output("cmp_err_valid", 32'(err_valid), 32'(m_err_valid));
            if (m_err_valid) check_output("cmp_err_id", 32'(err_id), 32'(m_err_id));
        end
    end

    function automatic logic [3:0] stall_all();
        logic [3:0] m = '0;
        for (int w = 0; w < NW; w++) if (wait_on[w] != -1) m[w] = 1'b1;
        return m;
    endfunction

    task automatic apply_stimulus(bit rv, int wid, int id, int sm1, bit av, int aid, bit rr);
        req_valid   = rv;
        req_wid     = 2'(wid);
        req_id      = 3'(id);
        req_size_m1 = 2'(sm1);
        abort_valid = av;
        abort_id    = 3'(aid);
        rel_ready   = rr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(int wid, int id, int sm1);
        apply_stimulus(1, wid, id, sm1, 0, 0, 1);
        step();
    endtask

    task automatic idle(bit rr);
        apply_stimulus(0, 0, 0, 0, 0, 0, rr);
        step();
    endtask

    int sz_tab [NB];

    initial begin
        reset_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_rel_valid", 32'(rel_valid), 0);
        check_output("rst_stalled", 32'(stalled_mask), 0);
        check_output("rst_err_valid", 32'(err_valid), 0);
        reset_n = 1'b1;
        step();

        $display("[TB] three-warp barrier");
        arrive(0, 3, 2);
        check_output("t1_stall_a", 32'(stalled_mask), 32'b0001);
        arrive(1, 3, 2);
        check_output("t1_stall_b", 32'(stalled_mask), 32'b0011);
        arrive(2, 3, 2);
        check_output("t1_rel_valid", 32'(rel_valid), 1);
        check_output("t1_rel_id", 32'(rel_id), 3);
        check_output("t1_rel_wmask", 32'(rel_wmask), 32'b0111);
        check_output("t1_rel_abort", 32'(rel_abort), 0);
        check_output("t1_stall_c", 32'(stalled_mask), 0);
        idle(1);
        check_output("t1_rel_drop", 32'(rel_valid), 0);

        $display("[TB] single-warp barrier");
        arrive(0, 5, 0);
        check_output("t2_rel_id", 32'(rel_id), 5);
        check_output("t2_rel_wmask", 32'(rel_wmask), 32'b0001);
        check_output("t2_stall", 32'(stalled_mask), 0);
        idle(1);

        $display("[TB] abort");
        arrive(0, 1, 3);
        arrive(1, 1, 3);
        apply_stimulus(0, 0, 0, 0, 1, 1, 1);
        step();
        check_output("t3_rel_abort", 32'(rel_abort), 1);
        check_output("t3_rel_wmask", 32'(rel_wmask), 32'b0011);
        apply_stimulus(0, 0, 0, 0, 1, 1, 1);
        step();
        check_output("t3_err_valid", 32'(err_valid), 1);
        check_output("t3_err_id", 32'(err_id), 1);
        idle(1);
        check_output("t3_err_pulse", 32'(err_valid), 0);

        $display("[TB] protocol errors");
        arrive(2, 0, 2);
        arrive(2, 0, 2);
        check_output("t4_dup_err", 32'(err_valid), 1);
        check_output("t4_dup_stall", 32'(stalled_mask), 32'b0100);
        arrive(3, 0, 1);
        check_output("t4_size_err", 32'(err_valid), 1);
        check_output("t4_size_stall", 32'(stalled_mask), 32'b0100);
        apply_stimulus(0, 0, 0, 0, 1, 0, 1);
        step();
        idle(1);

        $display("[TB] backpressure");
        arrive(0, 2, 1);
        apply_stimulus(1, 1, 6, 0, 0, 0, 0);
        step();
        apply_stimulus(1, 3, 2, 1, 0, 0, 0);
        #1;
        check_output("t5_stall_ready", 32'(req_ready), 0);
        step();
        check_output("t5_hold_id", 32'(rel_id), 6);
        check_output("t5_hold_wmask", 32'(rel_wmask), 32'b0010);
        apply_stimulus(1, 3, 2, 1, 0, 0, 1);
        #1;
        check_output("t5_go_ready", 32'(req_ready), 1);
        step();
        check_output("t5_b2b_valid", 32'(rel_valid), 1);
        check_output("t5_b2b_id", 32'(rel_id), 2);
        check_output("t5_b2b_wmask", 32'(rel_wmask), 32'b1001);
        idle(1);

        $display("[TB] async reset");
        arrive(0, 4, 2);
        arrive(1, 7, 3);
        apply_stimulus(1, 2, 5, 0, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t6_rel_valid", 32'(rel_valid), 0);
        check_output("t6_rel_id", 32'(rel_id), 0);
        check_output("t6_rel_wmask", 32'(rel_wmask), 0);
        check_output("t6_stall", 32'(stalled_mask), 0);
        check_output("t6_err", 32'(err_valid), 0);
        step();
        step();
        reset_n = 1'b1;
        arrive(3, 5, 0);
        check_output("t6_post_id", 32'(rel_id), 5);
        check_output("t6_post_wmask", 32'(rel_wmask), 32'b1000);

        $display("[TB] random traffic");
        for (int b = 0; b < NB; b++) sz_tab[b] = $urandom_range(0, 3);
        for (int c = 0; c < 3000; c++) begin
            int id, sm1;
            id  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
            sm1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : sz_tab[id];
            apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3), id, sm1,
                           $urandom_range(0, 9) == 0, $urandom_range(0, 7),
                           $urandom_range(0, 9) < 7);
            step();
        end
        idle(1);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
